// File: rtl/bcd_segment_encoder.sv
// bcd_segment_encoder
//   Converts an unsigned binary value into eight active-low seven-segment
//   patterns using a bit-serial double-dabble (shift / add-3) conversion.
//   Leading-zero digits can be blanked. Values above 99,999,999 show dashes.
//   The segment outputs are registered and change only when a conversion
//   completes, so the downstream display driver never sees a partial frame.
//
//   state  | meaning
//   IDLE   | waiting for start; the last frame is held on seg0..seg7
//   SHIFT  | one binary bit shifted into the BCD register per cycle
//   ENCODE | one cycle: BCD digits -> segment patterns, done pulse
//
// Parameters
//   WIDTH     binary input width, 4..27
//   BLANK_LZ  1: blank leading-zero digits (seg0 always shown), 0: show all
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   start       conversion request, sampled only in IDLE
//   value       binary input, captured on the accepted start edge
//   busy        high while a conversion is in progress
//   done        one-cycle pulse, new seg values visible in the same cycle
//   seg0..seg7  active-low patterns (bit0 = a .. bit6 = g), seg0 = LS digit

module bcd_segment_encoder #(
    parameter int WIDTH    = 27,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2,
    output logic [6:0]       seg3,
    output logic [6:0]       seg4,
    output logic [6:0]       seg5,
    output logic [6:0]       seg6,
    output logic [6:0]       seg7
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sh_q;
    logic [31:0]      bcd_q;
    logic [31:0]      bcd_adj;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0][6:0]  seg_q;
    logic [7:0][6:0]  seg_frame;

    logic capture;
    logic shift_en;
    logic encode;
    logic last_bit;

    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = ENCODE;
            ENCODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output / control decode
    always_comb begin
        capture  = 1'b0;
        shift_en = 1'b0;
        encode   = 1'b0;
        case (state)
            IDLE:    capture  = start;
            SHIFT:   shift_en = 1'b1;
            ENCODE:  encode   = 1'b1;
            default: ;
        endcase
    end

    // add 3 to every digit >= 5 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // frame build: scan from the top digit down, blanking until the first
    // non-zero digit is seen; seg0 is always shown
    always_comb begin
        logic nz_seen;
        nz_seen   = 1'b0;
        seg_frame = '0;
        for (int k = 7; k >= 0; k--) begin
            nz_seen = nz_seen | (bcd_q[4*k +: 4] != 4'd0);
            if (ovf_q) begin
                seg_frame[k] = 7'h3F;
            end else if (BLANK_LZ && !nz_seen && (k != 0)) begin
                seg_frame[k] = 7'h7F;
            end else begin
                seg_frame[k] = digit_pattern(bcd_q[4*k +: 4]);
            end
        end
    end

    // datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= {8{7'h7F}};
        end else begin
            done_q <= encode;
            if (capture) begin
                sh_q    <= value;
                bcd_q   <= '0;
                bit_cnt <= '0;
                ovf_q   <= (32'(value) > 32'd99_999_999);
                busy_q  <= 1'b1;
            end
            if (shift_en) begin
                sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
                bcd_q <= {bcd_adj[30:0], sh_q[WIDTH-1]};
                // a carry falling off the top digit is itself an overflow
                ovf_q <= ovf_q | bcd_adj[31];
                if (bit_cnt != CW'(WIDTH)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (encode) begin
                seg_q  <= seg_frame;
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];

endmodule
